// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// (IF) and the load/store stage (D). Each access is a request/acknowledge
// transaction. Grants alternate under contention. Data accesses with a bad size
// code or a misaligned address are rejected locally and never reach memory.
//
// Handshake: a requester holds *_req until its one-cycle *_ready pulse and must
// drop or change the request in the cycle after ready. mem_req is held with
// stable mem_* fields until a one-cycle mem_ack arrives; mem_rdata is valid
// with mem_ack. An mem_ack outside BUSY is ignored.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [2:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                last_d_q, last_d_d;   // 1: last grant went to D, 0: to IF
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [2:0]          mem_size_q, mem_size_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_ready_q, if_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                d_fault_q, d_fault_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic                d_bad;
   logic                pick_d;

   // Size/alignment legality of the pending data request.
   always_comb begin
      d_bad = 1'b1;
      case (d_size)
         3'b000, 3'b100: d_bad = 1'b0;
         3'b001, 3'b101: d_bad = d_addr[0];
         3'b010:         d_bad = |d_addr[1:0];
         default:        d_bad = 1'b1;
      endcase
   end

   // D wins when it is alone or when IF had the previous grant.
   assign pick_d = d_req && (!if_req || !last_d_q);

   // Next-state and registered-output computation for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      d_fault_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               last_d_d = pick_d;
               if (pick_d && d_bad) begin
                  // Rejected access: answer directly, memory never sees it.
                  d_ready_d = 1'b1;
                  d_fault_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = pick_d ? d_we : 1'b0;
                  mem_size_d  = pick_d ? d_size : 3'b010;
                  mem_addr_d  = pick_d ? d_addr : if_addr;
                  mem_wdata_d = pick_d ? d_wdata : '0;
                  state_d     = BUSY;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               if (last_d_q) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = mem_we_q ? '0 : mem_rdata;
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= 3'b000;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         d_fault_q   <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         d_fault_q   <= d_fault_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ready  = if_ready_q;
   assign if_rdata  = if_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_fault   = d_fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory responder with programmable wait
// states, a ready monitor that pops an expected-response queue, and one task
// per scenario. Inputs change on the falling edge; outputs are sampled there.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ready;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [2:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic          d_fault;
   logic          mem_req;
   logic          mem_we;
   logic [2:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_fault(d_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------- shared bench state ----------------
   int          tests = 0;
   int          fails = 0;
   logic [33:0] exp_q[$];           // {is_d, fault, data}
   logic [33:0] mon_e;
   int          mem_lat    = 1;     // mem_req cycles until ack (k)
   logic        use_fixed  = 1'b0;
   logic [31:0] fixed_val  = '0;
   int          stale_acks = 0;
   int          mem_cnt    = 0;
   logic [31:0] last_if    = '0;
   logic [31:0] last_d     = '0;

   // ---------------- memory responder ----------------
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
         end else if (stale_acks > 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            stale_acks--;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = use_fixed ? fixed_val : (mem_addr ^ KEY);
               mem_cnt   = 0;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (if_ready && d_ready) begin
               tests++;
               fails++;
               $display("FAIL ready_exclusive: if_ready=1 d_ready=1, expected at most one");
            end else if (if_ready || d_ready) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_ready: if_ready=%0b d_ready=%0b, expected no response",
                           if_ready, d_ready);
               end else begin
                  mon_e = exp_q.pop_front();
                  if ({d_ready, d_fault} !== mon_e[33:32] ||
                      (!mon_e[32] && ((d_ready ? d_rdata : if_rdata) !== mon_e[31:0]))) begin
                     fails++;
                     $display("FAIL scoreboard: got d=%0b fault=%0b data=%h, expected d=%0b fault=%0b data=%h",
                              d_ready, d_fault, d_ready ? d_rdata : if_rdata,
                              mon_e[33], mon_e[32], mon_e[31:0]);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic clear_inputs();
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_size  = 3'b000;
      d_addr  = '0;
      d_wdata = '0;
   endtask

   function automatic logic model_fault(logic [2:0] s, logic [31:0] a);
      case (s)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return a[0];
         3'b010:         return a[1:0] != 2'b00;
         default:        return 1'b1;
      endcase
   endfunction

   function automatic logic [2:0] pick_size(int i);
      case (i)
         0: return 3'b000;
         1: return 3'b001;
         2: return 3'b010;
         3: return 3'b100;
         4: return 3'b101;
         5: return 3'b011;
         default: return 3'b110;
      endcase
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      tests++;
      if ({if_ready, d_ready, d_fault, mem_req, mem_we} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b, expected 00000", {if_ready, d_ready, d_fault, mem_req, mem_we});
      end
      tests++;
      if ({mem_size, mem_addr, mem_wdata} !== 67'b0) begin
         fails++;
         $display("FAIL reset_mem_fields: got size=%b addr=%h wdata=%h, expected 0", mem_size, mem_addr, mem_wdata);
      end
      tests++;
      if ({if_rdata, d_rdata} !== 64'b0) begin
         fails++;
         $display("FAIL reset_rdata: got if=%h d=%h, expected 0", if_rdata, d_rdata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      use_fixed = 1'b1;
      fixed_val = 32'h0050_0093;
      mem_lat   = 2;
      if_req    = 1'b1;
      if_addr   = 32'h100;
      exp_q.push_back({1'b0, 1'b0, 32'h0050_0093});
      last_if   = 32'h0050_0093;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         tests++;
         if (mem_req !== (c <= 2)) begin
            fails++;
            $display("FAIL fetch_mem_req c%0d: got %0b, expected %0b", c, mem_req, (c <= 2));
         end
         tests++;
         if ({if_ready, d_ready} !== {(c == 3), 1'b0}) begin
            fails++;
            $display("FAIL fetch_ready c%0d: got if=%0b d=%0b, expected if=%0b d=0", c, if_ready, d_ready, (c == 3));
         end
         if (c == 1) begin
            tests++;
            if ({mem_we, mem_size, mem_addr, mem_wdata} !== {1'b0, 3'b010, 32'h100, 32'h0}) begin
               fails++;
               $display("FAIL fetch_fields: got we=%0b size=%b addr=%h wdata=%h, expected 0 010 100 0",
                        mem_we, mem_size, mem_addr, mem_wdata);
            end
         end
         if (c == 3) begin
            tests++;
            if (if_rdata !== 32'h0050_0093) begin
               fails++;
               $display("FAIL fetch_rdata: got %h, expected 00500093", if_rdata);
            end
            if_req = 1'b0;
         end
      end
      use_fixed = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stale_idle();
      stale_acks = 3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if ({mem_req, if_ready, d_ready, d_fault, if_rdata, d_rdata} !== {4'b0, last_if, last_d}) begin
            fails++;
            $display("FAIL stale_idle c%0d: got req=%0b rdy=%0b%0b flt=%0b if=%h d=%h, expected 0 00 0 if=%h d=%h",
                     c, mem_req, if_ready, d_ready, d_fault, if_rdata, d_rdata, last_if, last_d);
         end
      end
   endtask

   task automatic test_contention();
      mem_lat = 1;
      if_req  = 1'b1;
      if_addr = 32'h400;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_size  = 3'b010;
      d_addr  = 32'h800;
      exp_q.push_back({1'b1, 1'b0, 32'h800 ^ KEY});
      exp_q.push_back({1'b0, 1'b0, 32'h400 ^ KEY});
      exp_q.push_back({1'b1, 1'b0, 32'h800 ^ KEY});
      exp_q.push_back({1'b0, 1'b0, 32'h400 ^ KEY});
      for (int c = 1; c <= 11; c++) begin
         logic       rdy;
         logic       is_d;
         logic [1:0] exp_rdy;
         @(negedge clk);
         rdy     = (c % 3 == 2);
         is_d    = ((c / 3) % 2 == 0);
         exp_rdy = rdy ? (is_d ? 2'b01 : 2'b10) : 2'b00;
         tests++;
         if ({if_ready, d_ready} !== exp_rdy) begin
            fails++;
            $display("FAIL contention_ready c%0d: got if=%0b d=%0b, expected %b", c, if_ready, d_ready, exp_rdy);
         end
         if (c % 3 == 1) begin
            tests++;
            if ({mem_req, mem_addr} !== {1'b1, (is_d ? 32'h800 : 32'h400)}) begin
               fails++;
               $display("FAIL contention_grant c%0d: got req=%0b addr=%h, expected req=1 addr=%h",
                        c, mem_req, mem_addr, is_d ? 32'h800 : 32'h400);
            end
         end
         if (c == 11) begin
            if_req = 1'b0;
            d_req  = 1'b0;
         end
      end
      last_if = 32'h400 ^ KEY;
      last_d  = 32'h800 ^ KEY;
      @(negedge clk);
   endtask

   task automatic test_store();
      mem_lat = 1;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_size  = 3'b001;
      d_addr  = 32'h202;
      d_wdata = 32'hBEEF;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      @(negedge clk);
      tests++;
      if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 3'b001, 32'h202, 32'hBEEF}) begin
         fails++;
         $display("FAIL store_fields: got req=%0b we=%0b size=%b addr=%h wdata=%h, expected 1 1 001 202 0000beef",
                  mem_req, mem_we, mem_size, mem_addr, mem_wdata);
      end
      @(negedge clk);
      tests++;
      if ({d_ready, d_fault, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         fails++;
         $display("FAIL store_resp: got rdy=%0b flt=%0b rdata=%h, expected 1 0 0", d_ready, d_fault, d_rdata);
      end
      clear_inputs();
      last_d = '0;
      @(negedge clk);
   endtask

   task automatic test_faults();
      logic [2:0]  sz[3];
      logic [31:0] ad[3];
      sz[0] = 3'b010; ad[0] = 32'h203;
      sz[1] = 3'b001; ad[1] = 32'h201;
      sz[2] = 3'b011; ad[2] = 32'h300;
      for (int i = 0; i < 3; i++) begin
         d_req  = 1'b1;
         d_we   = 1'b0;
         d_size = sz[i];
         d_addr = ad[i];
         exp_q.push_back({1'b1, 1'b1, 32'h0});
         @(negedge clk);
         tests++;
         if ({d_ready, d_fault, mem_req} !== 3'b110) begin
            fails++;
            $display("FAIL fault%0d_resp: got rdy=%0b flt=%0b req=%0b, expected 1 1 0", i, d_ready, d_fault, mem_req);
         end
         clear_inputs();
         @(negedge clk);
         tests++;
         if ({d_ready, d_fault, mem_req} !== 3'b000) begin
            fails++;
            $display("FAIL fault%0d_after: got rdy=%0b flt=%0b req=%0b, expected 0 0 0", i, d_ready, d_fault, mem_req);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         logic        is_d;
         logic        flt;
         logic [31:0] a;
         int          n;
         int          exp_n;
         is_d    = 1'($urandom_range(0, 1));
         mem_lat = $urandom_range(1, 3);
         a       = 32'h1000 | (32'($urandom_range(0, 63)) << 2);
         if (is_d) begin
            a       = a | 32'($urandom_range(0, 3));
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_size  = pick_size($urandom_range(0, 6));
            d_addr  = a;
            d_wdata = $urandom;
            flt     = model_fault(d_size, a);
            exp_q.push_back({1'b1, flt, (d_we ? 32'h0 : (a ^ KEY))});
         end else begin
            if_req  = 1'b1;
            if_addr = a;
            flt     = 1'b0;
            exp_q.push_back({1'b0, 1'b0, a ^ KEY});
         end
         exp_n = flt ? 1 : mem_lat + 1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(if_ready || d_ready) && n < 20);
         tests++;
         if (n !== exp_n) begin
            fails++;
            $display("FAIL random%0d_latency: got %0d cycles, expected %0d", it, n, exp_n);
         end
         clear_inputs();
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      mem_lat = 6;
      if_req  = 1'b1;
      if_addr = 32'h500;
      repeat (2) @(negedge clk);
      tests++;
      if (mem_req !== 1'b1) begin
         fails++;
         $display("FAIL midreset_busy: got mem_req=%0b, expected 1", mem_req);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL midreset_async: got mem_req=%0b, expected 0", mem_req);
      end
      clear_inputs();
      repeat (2) @(negedge clk);
      reset      = 1'b0;
      stale_acks = 2;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests++;
         if ({mem_req, if_ready, d_ready} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_quiet c%0d: got req=%0b rdy=%0b%0b, expected 000", c, mem_req, if_ready, d_ready);
         end
      end
      mem_lat = 1;
      if_req  = 1'b1;
      if_addr = 32'h600;
      exp_q.push_back({1'b0, 1'b0, 32'h600 ^ KEY});
      @(negedge clk);
      tests++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
         fails++;
         $display("FAIL midreset_next_req: got req=%0b addr=%h, expected 1 600", mem_req, mem_addr);
      end
      @(negedge clk);
      tests++;
      if (if_ready !== 1'b1) begin
         fails++;
         $display("FAIL midreset_next_ready: got %0b, expected 1", if_ready);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_stale_idle();
      test_contention();
      test_store();
      test_faults();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_responses: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
